output_port_controller: RTL and testbench

- Output-side counterpart of the router's input port controllers: one instance per router output port (East, North, West, South, Local).
- Arbitrates among the five input port controllers' request lines for this port using round-robin.
- Returns a one-cycle grant pulse to the winner and latches the winner's packet.
- Writes the packet into the downstream link FIFO (neighbour router's input buffer or local network interface) with a full-aware write handshake.

---
 rtl/output_port_controller_if.sv | 24 ++
 rtl/output_port_controller.sv | 109 ++++++++++
 tb/tb_output_port_controller.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_port_controller_if.sv
// Bundle between one router output port and the five input controllers plus
// the downstream link FIFO; master is the output port controller.
interface output_port_controller_if #(
   parameter int dataWidth = 32,
   parameter int cntWidth  = 16
);
   logic [4:0]             reqIn;
   logic [5*dataWidth-1:0] packetIn;
   logic [4:0]             gntIn;
   logic                   full;
   logic                   wrEn;
   logic [dataWidth-1:0]   PacketOut;
   logic [cntWidth-1:0]    pktCount;

   modport master (
      input  reqIn, packetIn, full,
      output gntIn, wrEn, PacketOut, pktCount
   );

   modport slave (
      output reqIn, packetIn, full,
      input  gntIn, wrEn, PacketOut, pktCount
   );
endinterface

// File: rtl/output_port_controller.sv
// Router output port: round-robin arbitration over five input controllers,
// one-cycle grant pulse, and full-aware write of the winner's packet downstream.
//
// state | meaning
// IDLE  | no packet held; arbitrate among pending requests
// GRANT | grant pulse is on the wire; requests ignored
// SEND  | packet held; write downstream as soon as the FIFO has room
module output_port_controller #(
   parameter int dataWidth = 32,
   parameter int portId    = 0,
   parameter int cntWidth  = 16
) (
   input logic                 clk,
   input logic                 reset,
   output_port_controller_if.master port
);

   if (portId < 0 || portId > 4) begin : g_bad_port
      $error("output_port_controller: portId must be 0..4");
   end

   typedef enum logic [1:0] {IDLE, GRANT, SEND} state_t;

   state_t                state, state_nxt;
   logic [2:0]            last_gnt, last_gnt_nxt;
   logic [dataWidth-1:0]  data_buf, data_buf_nxt;
   logic [4:0]            gnt, gnt_nxt;
   logic                  wr_en, wr_en_nxt;
   logic [cntWidth-1:0]   pkt_count, pkt_count_nxt;

   logic [dataWidth-1:0]  slice [5];
   logic                  found;
   logic [2:0]            win;
   logic [2:0]            cand;

   for (genvar i = 0; i < 5; i++) begin : g_slice
      assign slice[i] = port.packetIn[i*dataWidth +: dataWidth];
   end

   // search starts one past the last winner so every requester is served in turn
   always_comb begin
      found = 1'b0;
      win   = 3'd0;
      cand  = 3'd0;
      for (int k = 1; k <= 5; k++) begin
         cand = 3'((int'(last_gnt) + k) % 5);
         if (!found && port.reqIn[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      last_gnt_nxt  = last_gnt;
      data_buf_nxt  = data_buf;
      gnt_nxt       = 5'b00000;
      wr_en_nxt     = 1'b0;
      pkt_count_nxt = pkt_count;
      case (state)
         IDLE: begin
            if (found) begin
               gnt_nxt      = 5'b00001 << win;
               data_buf_nxt = slice[win];
               last_gnt_nxt = win;
               state_nxt    = GRANT;
            end
         end
         GRANT: begin
            state_nxt = SEND;
         end
         SEND: begin
            if (!port.full) begin
               wr_en_nxt     = 1'b1;
               pkt_count_nxt = pkt_count + cntWidth'(1);
               state_nxt     = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         last_gnt  <= 3'd4;
         data_buf  <= '0;
         gnt       <= 5'b00000;
         wr_en     <= 1'b0;
         pkt_count <= '0;
      end else begin
         state     <= state_nxt;
         last_gnt  <= last_gnt_nxt;
         data_buf  <= data_buf_nxt;
         gnt       <= gnt_nxt;
         wr_en     <= wr_en_nxt;
         pkt_count <= pkt_count_nxt;
      end
   end

   assign port.gntIn     = gnt;
   assign port.wrEn      = wr_en;
   assign port.PacketOut = data_buf;
   assign port.pktCount  = pkt_count;

endmodule

// File: tb/tb_output_port_controller.sv
// Bench for output_port_controller: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a transaction-level model.
module tb_output_port_controller;
   localparam int DW = 32;
   localparam int CW = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   cmp_on = 1'b0;

   output_port_controller_if #(.dataWidth(DW), .cntWidth(CW)) bus ();

   output_port_controller #(.dataWidth(DW), .portId(0), .cntWidth(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .port  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a packet in flight needs one turnaround cycle after its grant,
   // then leaves on the first cycle the FIFO has room.
   int              m_last = 4;
   bit              m_busy = 1'b0;
   bit              m_turn = 1'b0;
   logic [4:0]      e_gnt  = '0;
   logic            e_wr   = 1'b0;
   logic [DW-1:0]   e_out  = '0;
   int              e_cnt  = 0;

   function automatic int rr_pick(input logic [4:0] req, input int last);
      for (int k = 1; k <= 5; k++)
         if (req[(last + k) % 5]) return (last + k) % 5;
      return -1;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_last <= 4;
         m_busy <= 1'b0;
         m_turn <= 1'b0;
         e_gnt  <= '0;
         e_wr   <= 1'b0;
         e_out  <= '0;
         e_cnt  <= 0;
      end else begin
         e_gnt <= '0;
         e_wr  <= 1'b0;
         if (!m_busy) begin
            if (rr_pick(bus.reqIn, m_last) >= 0) begin
               e_gnt  <= 5'(1 << rr_pick(bus.reqIn, m_last));
               e_out  <= bus.packetIn[rr_pick(bus.reqIn, m_last)*DW +: DW];
               m_last <= rr_pick(bus.reqIn, m_last);
               m_busy <= 1'b1;
               m_turn <= 1'b1;
            end
         end else if (m_turn) begin
            m_turn <= 1'b0;
         end else if (!bus.full) begin
            e_wr   <= 1'b1;
            e_cnt  <= (e_cnt + 1) % (1 << CW);
            m_busy <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         check("model_gnt", 64'(bus.gntIn), 64'(e_gnt));
         check("model_wr",  64'(bus.wrEn), 64'(e_wr));
         check("model_out", 64'(bus.PacketOut), 64'(e_out));
         check("model_cnt", 64'(bus.pktCount), 64'(e_cnt));
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_wr(input string name);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!bus.wrEn && k < 20);
      check(name, 64'(bus.wrEn), 64'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.reqIn    = '0;
      bus.packetIn = '0;
      bus.full     = 1'b0;
      reset        = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_gnt", 64'(bus.gntIn), 64'(0));
      check("rst_wr",  64'(bus.wrEn), 64'(0));
      check("rst_out", 64'(bus.PacketOut), 64'(0));
      check("rst_cnt", 64'(bus.pktCount), 64'(0));
      reset  = 1'b1;
      cmp_on = 1'b1;

      // single request, unblocked
      bus.packetIn[2*DW +: DW] = 32'hA5A5_0001;
      bus.reqIn = 5'b00100;
      @(negedge clk);
      check("t1_gnt", 64'(bus.gntIn), 64'h04);
      bus.reqIn = 5'b00000;
      @(negedge clk);
      check("t1_gnt_pulse", 64'(bus.gntIn), 64'h00);
      check("t1_wr_early", 64'(bus.wrEn), 64'(0));
      @(negedge clk);
      check("t1_wr", 64'(bus.wrEn), 64'(1));
      check("t1_out", 64'(bus.PacketOut), 64'hA5A5_0001);
      check("t1_cnt", 64'(bus.pktCount), 64'(1));
      @(negedge clk);
      check("t1_wr_once", 64'(bus.wrEn), 64'(0));

      // all five requesting continuously
      do_reset();
      for (int i = 0; i < 5; i++) bus.packetIn[i*DW +: DW] = 32'(i + 1);
      bus.reqIn = 5'b11111;
      for (int g = 0; g < 6; g++) begin
         @(negedge clk);
         check("t2_gnt", 64'(bus.gntIn), 64'(1 << (g % 5)));
         @(negedge clk);
         check("t2_wr_early", 64'(bus.wrEn), 64'(0));
         @(negedge clk);
         check("t2_wr", 64'(bus.wrEn), 64'(1));
         check("t2_out", 64'(bus.PacketOut), 64'((g % 5) + 1));
      end
      bus.reqIn = 5'b00000;

      // wrap of the round-robin search past port 4
      for (int i = 0; i < 5; i++) bus.packetIn[i*DW +: DW] = 32'hC0DE_0000 + 32'(i);
      @(negedge clk);
      bus.reqIn = 5'b01000;
      @(negedge clk);
      check("t3_gnt3", 64'(bus.gntIn), 64'h08);
      bus.reqIn = 5'b01001;
      repeat (2) @(negedge clk);
      check("t3_out3", 64'(bus.PacketOut), 64'hC0DE_0003);
      @(negedge clk);
      check("t3_gnt0", 64'(bus.gntIn), 64'h01);
      bus.reqIn = 5'b01000;
      repeat (2) @(negedge clk);
      check("t3_out0", 64'(bus.PacketOut), 64'hC0DE_0000);
      @(negedge clk);
      check("t3_gnt3b", 64'(bus.gntIn), 64'h08);
      bus.reqIn = 5'b00000;
      repeat (2) @(negedge clk);
      check("t3_wr", 64'(bus.wrEn), 64'(1));
      check("t3_cnt", 64'(bus.pktCount), 64'(9));

      // downstream full stalls the write
      bus.packetIn[1*DW +: DW] = 32'h1111_BEEF;
      bus.reqIn = 5'b00010;
      bus.full  = 1'b1;
      @(negedge clk);
      check("t4_gnt", 64'(bus.gntIn), 64'h02);
      bus.reqIn = 5'b00000;
      repeat (10) begin
         @(negedge clk);
         check("t4_no_wr", 64'(bus.wrEn), 64'(0));
         check("t4_hold", 64'(bus.PacketOut), 64'h1111_BEEF);
      end
      bus.full = 1'b0;
      @(negedge clk);
      check("t4_wr", 64'(bus.wrEn), 64'(1));
      check("t4_cnt", 64'(bus.pktCount), 64'(10));
      @(negedge clk);
      check("t4_wr_once", 64'(bus.wrEn), 64'(0));
      check("t4_cnt_once", 64'(bus.pktCount), 64'(10));

      // reset while waiting in SEND
      bus.packetIn[2*DW +: DW] = 32'h2222_0005;
      bus.reqIn = 5'b00100;
      bus.full  = 1'b1;
      @(negedge clk);
      bus.reqIn = 5'b00000;
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("t5_gnt", 64'(bus.gntIn), 64'(0));
      check("t5_wr", 64'(bus.wrEn), 64'(0));
      check("t5_out", 64'(bus.PacketOut), 64'(0));
      check("t5_cnt", 64'(bus.pktCount), 64'(0));
      @(negedge clk);
      reset = 1'b1;
      bus.full = 1'b0;
      bus.packetIn[0*DW +: DW] = 32'h5000_0000;
      bus.packetIn[4*DW +: DW] = 32'h5000_0004;
      bus.reqIn = 5'b10001;
      @(negedge clk);
      check("t5_gnt0", 64'(bus.gntIn), 64'h01);
      bus.reqIn = 5'b10000;
      repeat (2) @(negedge clk);
      check("t5_out0", 64'(bus.PacketOut), 64'h5000_0000);
      @(negedge clk);
      check("t5_gnt4", 64'(bus.gntIn), 64'h10);
      bus.reqIn = 5'b00000;
      repeat (2) @(negedge clk);
      check("t5_out4", 64'(bus.PacketOut), 64'h5000_0004);

      // packet counter wraps
      do_reset();
      bus.reqIn = 5'b11111;
      for (int p = 1; p <= 16; p++) begin
         wait_wr("t6_wr");
         if (p == 15) check("t6_cnt_max", 64'(bus.pktCount), 64'hF);
         if (p == 16) check("t6_cnt_wrap", 64'(bus.pktCount), 64'h0);
      end
      bus.reqIn = 5'b00000;

      // randomized traffic against the model
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (cyc == 1500) begin
            #2 reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
         end
         for (int i = 0; i < 5; i++) begin
            if (bus.gntIn[i]) begin
               bus.reqIn[i] = 1'b0;
            end else if (!bus.reqIn[i] && $urandom_range(0, 3) == 0) begin
               bus.packetIn[i*DW +: DW] = $urandom;
               bus.reqIn[i] = 1'b1;
            end
         end
         bus.full = ($urandom_range(0, 2) == 0);
      end
      bus.reqIn = '0;
      bus.full  = 1'b0;
      repeat (5) @(negedge clk);
      cmp_on = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
